// File: rtl/multi_channel_avg_filter.sv
// multi_channel_avg_filter: per-channel 2**LOG2_N-tap boxcar average with bypass, flush and fill status
//   clk       system clock
//   reset     asynchronous active-high reset
//   read      sample-available level; each 0->1 transition accepts one sample
//   data_in   packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   bypass    1 = data_out carries the raw sample (filter state still updates)
//   clear     synchronous flush of all filter state
//   data_out  packed signed averaged/bypassed samples, registered
//   out_valid one-cycle pulse when data_out updates
//   filled    high once N samples have been accepted since reset/clear
module multi_channel_avg_filter #(
   parameter int DATA_W   = 24,
   parameter int LOG2_N   = 3,
   parameter int CHANNELS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         read,
   input  logic [CHANNELS*DATA_W-1:0]   data_in,
   input  logic                         bypass,
   input  logic                         clear,
   output logic [CHANNELS*DATA_W-1:0]   data_out,
   output logic                         out_valid,
   output logic                         filled
);
   localparam int N     = 2**LOG2_N;
   localparam int ACC_W = DATA_W + LOG2_N;
   localparam int BUS_W = CHANNELS*DATA_W;
   logic                     r_prev_read, r_s1_valid, r_byp;
   logic [BUS_W-1:0]         r_x, r_old;
   logic [BUS_W-1:0]         r_mem [N];
   logic [LOG2_N-1:0]        r_wr_ptr;
   logic [LOG2_N:0]          r_count;
   logic signed [ACC_W-1:0]  r_sum [CHANNELS];
   logic signed [ACC_W-1:0]  w_sum_nxt [CHANNELS];
   logic [BUS_W-1:0]         w_out;
   logic                     w_accept, w_full;
   assign w_accept = read & ~r_prev_read;
   assign w_full   = r_count == (LOG2_N+1)'(N);
   assign filled   = w_full;
   // Until the window is full the evicted entry is treated as zero, so stale
   // buffer contents never need clearing.
   always_comb begin
      w_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_sum_nxt[c] = r_sum[c] + ACC_W'($signed(r_x[c*DATA_W +: DATA_W]))
                      - (w_full ? ACC_W'($signed(r_old[c*DATA_W +: DATA_W])) : '0);
         w_out[c*DATA_W +: DATA_W] = r_byp ? r_x[c*DATA_W +: DATA_W]
                                           : DATA_W'(w_sum_nxt[c] >>> LOG2_N);
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_read <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_byp       <= 1'b0;
         r_x         <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         data_out    <= '0;
         out_valid   <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) r_sum[c] <= '0;
      end else begin
         r_prev_read <= read;
         r_s1_valid  <= w_accept & ~clear;
         out_valid   <= r_s1_valid & ~clear;
         if (w_accept) begin
            r_x   <= data_in;
            r_byp <= bypass;
         end
         if (clear) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            data_out <= '0;
            for (int c = 0; c < CHANNELS; c++) r_sum[c] <= '0;
         end else if (r_s1_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= w_full ? r_count : r_count + 1'b1;
            data_out <= w_out;
            for (int c = 0; c < CHANNELS; c++) r_sum[c] <= w_sum_nxt[c];
         end
      end
   end
   // Oldest entry is read at the accept edge and overwritten one edge later;
   // the two-cycle accept spacing keeps the ports from colliding.
   always_ff @(posedge clk) begin
      if (w_accept) r_old <= r_mem[r_wr_ptr];
      if (r_s1_valid && !clear) r_mem[r_wr_ptr] <= r_x;
   end
endmodule

// File: tb/tb_multi_channel_avg_filter.sv
// tb_multi_channel_avg_filter: table, corner-case and random checks of the averaging filter
module tb_multi_channel_avg_filter;
   logic        clk, reset, read, bypass, clear;
   logic [47:0] data_in, data_out;
   logic        out_valid, filled;
   int          cnt = 0, errs = 0;
   int          h [2][$];

   typedef struct {int x0; int x1; int e0; int e1; bit f;} vec_t;
   vec_t tbl [10];

   multi_channel_avg_filter #(.DATA_W(24), .LOG2_N(3), .CHANNELS(2)) dut (
      .clk(clk), .reset(reset), .read(read), .data_in(data_in), .bypass(bypass),
      .clear(clear), .data_out(data_out), .out_valid(out_valid), .filled(filled));

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      cnt++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Floor-divided average of the last 8 accepted samples, zero padded.
   function automatic int avg(input int c);
      int s = 0;
      int n = h[c].size();
      for (int i = (n > 8 ? n - 8 : 0); i < n; i++) s += h[c][i];
      return s >= 0 ? s / 8 : -((-s + 7) / 8);
   endfunction

   function automatic longint ch(input int c);
      return c == 0 ? longint'($signed(data_out[23:0])) : longint'($signed(data_out[47:24]));
   endfunction

   task automatic flush_model();
      h[0].delete();
      h[1].delete();
   endtask

   task automatic accept(input int x0, input int x1, input bit byp);
      @(negedge clk);
      data_in = {x1[23:0], x0[23:0]};
      bypass  = byp;
      read    = 1;
      @(posedge clk);
      h[0].push_back(x0);
      h[1].push_back(x1);
      #1 chk("valid_early", out_valid, 0);
      @(negedge clk);
      read = 0;
      @(posedge clk);
      #1;
      chk("valid_pulse", out_valid, 1);
      chk("ch0", ch(0), byp ? x0 : avg(0));
      chk("ch1", ch(1), byp ? x1 : avg(1));
      chk("filled", filled, h[0].size() >= 8);
      @(posedge clk);
      #1 chk("valid_drop", out_valid, 0);
   endtask

   initial begin
      int pulses;
      logic [23:0] t0, t1;
      tbl[0] = '{20, -8,  2, -1, 0};
      tbl[1] = '{30, -8,  6, -2, 0};
      tbl[2] = '{100,-8, 18, -3, 0};
      tbl[3] = '{40, -8, 23, -4, 0};
      tbl[4] = '{30, -8, 27, -5, 0};
      tbl[5] = '{25, -8, 30, -6, 0};
      tbl[6] = '{50, -8, 36, -7, 0};
      tbl[7] = '{60, -8, 44, -8, 1};
      tbl[8] = '{70, -8, 50, -8, 1};
      tbl[9] = '{80, -8, 56, -8, 1};
      reset = 1; read = 0; bypass = 0; clear = 0; data_in = '0;
      #1;
      chk("rst_data", data_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_filled", filled, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;

      foreach (tbl[i]) begin
         accept(tbl[i].x0, tbl[i].x1, 0);
         chk($sformatf("tbl%0d_ch0", i), ch(0), tbl[i].e0);
         chk($sformatf("tbl%0d_ch1", i), ch(1), tbl[i].e1);
         chk($sformatf("tbl%0d_filled", i), filled, tbl[i].f);
      end

      for (int i = 0; i < 8; i++) accept(8388607, 0, 0);
      chk("max_pos", ch(0), 8388607);
      for (int i = 0; i < 8; i++) accept(-8388608, 0, 0);
      chk("max_neg", ch(0), -8388608);

      @(negedge clk);
      data_in = {24'd5, 24'd5};
      bypass = 0;
      read = 1;
      pulses = 0;
      h[0].push_back(5);
      h[1].push_back(5);
      repeat (5) begin
         @(posedge clk);
         #1 if (out_valid) pulses++;
      end
      @(negedge clk);
      read = 0;
      repeat (3) begin
         @(posedge clk);
         #1 if (out_valid) pulses++;
      end
      chk("held_read_pulses", pulses, 1);
      chk("held_read_ch0", ch(0), avg(0));

      @(negedge clk);
      data_in = {24'd7, 24'd7};
      read = 1;
      @(posedge clk);
      @(negedge clk);
      read = 0;
      clear = 1;
      @(posedge clk);
      #1;
      chk("clr_e1_valid", out_valid, 0);
      chk("clr_e1_data", data_out, 0);
      chk("clr_e1_filled", filled, 0);
      flush_model();
      @(negedge clk);
      clear = 0;
      @(posedge clk);
      #1 chk("clr_e1_late_valid", out_valid, 0);

      @(negedge clk);
      read = 1;
      clear = 1;
      @(posedge clk);
      @(negedge clk);
      clear = 0;
      @(posedge clk);
      #1 chk("clr_acc_valid1", out_valid, 0);
      @(posedge clk);
      #1 chk("clr_acc_valid2", out_valid, 0);
      @(negedge clk);
      read = 0;
      chk("clr_acc_filled", filled, 0);
      accept(16, 16, 0);
      chk("after_clr_16", ch(0), 2);

      @(negedge clk);
      clear = 1;
      @(negedge clk);
      clear = 0;
      flush_model();
      for (int i = 0; i < 8; i++) accept(8, 8, 0);
      accept(100, 100, 1);
      chk("bypass_out", ch(0), 100);
      accept(8, 8, 0);
      chk("unbypass_avg", ch(0), 19);

      @(negedge clk);
      data_in = {24'd50, 24'd50};
      read = 1;
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("arst_data", data_out, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_filled", filled, 0);
      @(negedge clk);
      read = 0;
      @(posedge clk);
      #1 chk("arst_e1_valid", out_valid, 0);
      @(negedge clk);
      reset = 0;
      flush_model();
      @(posedge clk);
      #1 chk("arst_after_valid", out_valid, 0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(9) == 0) begin
            @(negedge clk);
            clear = 1;
            @(negedge clk);
            clear = 0;
            flush_model();
            chk("rnd_clr_data", data_out, 0);
            chk("rnd_clr_filled", filled, 0);
         end else begin
            t0 = 24'($urandom);
            t1 = 24'($urandom);
            accept(int'($signed(t0)), int'($signed(t1)), $urandom_range(3) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
      $finish;
   end
endmodule

// File: doc/multi_channel_avg_filter.md
Name: multi_channel_avg_filter

Overview:
- Parametrised multi-channel moving-average (boxcar) filter for the audio path, placed between the CODEC input FIFO and the output stage.
- Each channel averages its last 2**LOG2_N samples using an internal circular buffer and a full-precision running sum. Division happens once, at the output, so no per-sample precision is lost.
- Adds bypass mode, synchronous flush, window-filled status and an output-valid strobe.

Parameters:
- DATA_W, 24: signed sample width per channel.
- LOG2_N, 3: log2 of window depth; N = 2**LOG2_N, with LOG2_N >= 1.
- CHANNELS, 2: number of independent channels, packed in the data buses.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  sample-available level from upstream; one sample is accepted per 0->1 transition.
- data_in  in  CHANNELS*DATA_W  packed signed samples; channel c occupies bits [c*DATA_W +: DATA_W].
- bypass  in  1  1 = output passes raw sample; filter state still updates.
- clear  in  1  synchronous flush of all filter state.
- data_out  out  CHANNELS*DATA_W  packed signed averaged (or bypassed) samples, registered.
- out_valid  out  1  one-cycle pulse when data_out has been updated.
- filled  out  1  high once N samples have been accepted since reset/clear.

Behaviour:
- Reset (async, any time, including mid-pipeline):
  - data_out=0, out_valid=0, filled=0.
  - All accumulators 0, write pointer 0, fill count 0, pipeline empty, previous-read register 0.
  - Buffer contents need not be cleared; the fill count masks them.
- Accept:
  - A sample is accepted at edge E0 when read=1 and registered previous read=0 (rising-edge detect). A held-high read accepts exactly once.
  - Minimum spacing between accepts is 2 cycles by construction.
- Pipeline stage 1 (edge E0):
  - Latch data_in, latch bypass.
  - Issue a synchronous buffer read of entry wr_ptr for all channels (the oldest sample).
- Pipeline stage 2 (edge E1):
  - Per channel: sum <= sum + x - old, where old = buffer entry if fill count == N, else 0.
  - Write x to buffer[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping modulo N.
  - Fill count increments, saturating at N.
  - data_out <= bypass_latched ? x : (new sum >>> LOG2_N).
  - out_valid = 1 for the single cycle following E1.
  - Latency: accept edge to data_out update is 2 edges.
- Arithmetic:
  - Accumulator width is DATA_W+LOG2_N, signed; it cannot overflow.
  - Output uses an arithmetic shift (floor toward −inf) and is truncated to DATA_W; the result always fits.
  - While not filled, the output is sum/N over a zero-padded window, not sum/count.
- filled: combinational (fill count == N) or registered equivalently; it asserts in the cycle after the E1 of the Nth accept.
- clear (sampled at clock edge, priority over accept and stage 2):
  - Zeroes accumulators, wr_ptr, fill count and data_out.
  - Drops any in-flight stage-2 update; out_valid=0.
  - An accept coinciding with clear is discarded.
  - The previous-read register still updates, so a read held high through clear is not re-accepted.
- bypass:
  - Affects only the data_out mux.
  - Toggling bypass mid-stream causes no discontinuity in filter state; the first non-bypass output equals the true window average.
- Channels are fully independent; identical control, separate accumulators and buffer lanes.
- Buffer: one N x (CHANNELS*DATA_W) array with one read port and one write port; no read/write collision occurs given accept spacing.

Test Plan (DATA_W=24, LOG2_N=3, CHANNELS=2):
1. Reset, then accept ch0 = 20, 30, 100, 40 (read pulsed 1 cycle high, 1 low) -> data_out ch0 = 2, 6, 18, 23, each 2 edges after accept with one out_valid pulse; filled=0.
2. Continue ch0 = 30, 25, 50, 60 -> 8th output 44 (sum 355) and filled=1; 9th input 70 -> 50 (sum 405, 20 evicted); 10th input 80 -> 56 (sum 455, 30 evicted).
3. ch1 constant −8 alongside ch0 -> ch1 outputs −1, −2, … −8, then holds −8; ch0 results unchanged from scenarios 1-2 (channel independence).
4. Eight accepts of 8388607 (max positive) on ch0 -> output reaches 8388607 with no wrap; then eight of −8388608 -> settles at −8388608.
5. read held high 5 cycles -> exactly one accept and one out_valid. Assert clear mid-window (including on E1) -> data_out=0, filled=0, no out_valid; next sample 16 -> output 2.
6. bypass=1 with input 100 after a filled window of 8s -> output 100; bypass=0, input 8 -> output (7*8+8... per true window) = 19 (window 8,8,8,8,8,8,100,8 = 156 → 19). Async reset asserted between E0 and E1 -> all outputs 0, no out_valid.
